// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and the OP-IMM encoder state type.
// Configuration macro: LI_EXPAND_EN adds the LUI+ADDI expansion states.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SLTI  = 3'b010;
    localparam logic [2:0] F3_SLTIU = 3'b011;
    localparam logic [2:0] F3_XORI  = 3'b100;
    localparam logic [2:0] F3_SRXI  = 3'b101;
    localparam logic [2:0] F3_ORI   = 3'b110;
    localparam logic [2:0] F3_ANDI  = 3'b111;

    localparam logic [6:0] F7_SRAI = 7'b0100000;
    localparam logic [6:0] F7_ZERO = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD
`ifdef LI_EXPAND_EN
        ,
        ST_EMIT_LUI,
        ST_EMIT_ADDI
`endif
    } enc_state_e;

    // Shift-immediate ops are the only ones with funct3[1:0] == 01.
    function automatic logic is_shift(input logic [2:0] funct3);
        return funct3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/itype_field_pack.sv
// Combinational field packer for OP-IMM words, with range check.
// Configuration macro: LI_EXPAND_EN adds the LUI / trailing ADDI words.
module itype_field_pack
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic            arith_i,
    input  logic [4:0]      rd_i,
    input  logic [4:0]      rs1_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [31:0]     instr_o,
    output logic            in_range_o
`ifdef LI_EXPAND_EN
    ,
    output logic [31:0]     lui_instr_o,
    output logic [31:0]     addi_instr_o,
    output logic            lo_zero_o,
    output logic            expand_ok_o
`endif
);

    logic       shift;
    logic [6:0] funct7;

    assign shift  = is_shift(funct3_i);
    // arith only matters for the right-shift encoding.
    assign funct7 = (funct3_i == F3_SRXI && arith_i) ? F7_SRAI : F7_ZERO;

    // Shifts need an unsigned 0..31 amount; others need imm[31:11] to be a sign extension.
    assign in_range_o = shift ? (imm_i[31:5] == '0)
                              : ((&imm_i[31:11]) | ~(|imm_i[31:11]));

    assign instr_o = shift ? {funct7, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OPIMM}
                           : {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};

`ifdef LI_EXPAND_EN
    logic [31:0] rounded;

    // The +0x800 compensates for ADDI sign-extending its 12-bit low part.
    assign rounded      = imm_i + 32'h0000_0800;
    assign lui_instr_o  = {rounded[31:12], rd_i, OPC_LUI};
    assign addi_instr_o = {imm_i[11:0], rd_i, F3_ADDI, rd_i, OPC_OPIMM};
    assign lo_zero_o    = (imm_i[11:0] == 12'h000);
    assign expand_ok_o  = (funct3_i == F3_ADDI) && (rs1_i == 5'd0);
`endif

endmodule

// File: rtl/itype_instr_encoder.sv
// RV32I OP-IMM instruction encoder with valid/ready on both sides and a
// registered output word.
// Configuration macro: LI_EXPAND_EN expands wide li-style ADDI constants
// into a LUI+ADDI pair; undefined, every out-of-range immediate is rejected.
module itype_instr_encoder
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_arith,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_err
);

    enc_state_e  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic [31:0] pk_instr;
    logic        pk_in_range;
    logic        accept;

`ifdef LI_EXPAND_EN
    logic [31:0] pend_q, pend_d;
    logic [31:0] pk_lui, pk_addi;
    logic        pk_lo_zero, pk_expand_ok;
`endif

    itype_field_pack u_pack (
        .funct3_i     (in_funct3),
        .arith_i      (in_arith),
        .rd_i         (in_rd),
        .rs1_i        (in_rs1),
        .imm_i        (in_imm),
        .instr_o      (pk_instr),
        .in_range_o   (pk_in_range)
`ifdef LI_EXPAND_EN
        ,
        .lui_instr_o  (pk_lui),
        .addi_instr_o (pk_addi),
        .lo_zero_o    (pk_lo_zero),
        .expand_ok_o  (pk_expand_ok)
`endif
    );

    // A HOLD word being taken this cycle frees the slot for a back-to-back request.
    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_HOLD && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != ST_IDLE);
    assign out_instr = instr_q;
    assign out_err   = err_q;

    // Next-state and output-word selection.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        instr_d = instr_q;
        err_d   = 1'b0;
`ifdef LI_EXPAND_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            ST_IDLE: ;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
`ifdef LI_EXPAND_EN
            ST_EMIT_LUI: begin
                if (out_ready) begin
                    state_d = ST_EMIT_ADDI;
                    instr_d = pend_q;
                end
            end
            ST_EMIT_ADDI: if (out_ready) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (pk_in_range) begin
                instr_d = pk_instr;
                state_d = ST_HOLD;
            end
`ifdef LI_EXPAND_EN
            else if (pk_expand_ok) begin
                // A zero low part needs no ADDI, so the LUI behaves as a single word.
                instr_d = pk_lui;
                pend_d  = pk_addi;
                state_d = pk_lo_zero ? ST_HOLD : ST_EMIT_LUI;
            end
`endif
            else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    // State, output word and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            err_q   <= 1'b0;
`ifdef LI_EXPAND_EN
            pend_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
`ifdef LI_EXPAND_EN
            pend_q  <= pend_d;
`endif
        end
    end

endmodule
